decode_stage: RTL

- Pipelined, parametrised decode stage between fetch and register-read/execute.
- Accepts a bundle of DECODE_WIDTH RISC-V RV32I instruction words per cycle with a valid/ready handshake.
- Decodes each lane into an extended OpInfo: fields, sign-extended immediate, illegal flag.
- Holds results in an output register backed by a one-entry skid buffer, so upstream ready is registered and back-pressure is lossless.

---
 rtl/decode_stage_pkg.sv | 67 ++++++
 rtl/decode_lane.sv | 126 ++++++++++++
 rtl/decode_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage.
// Immediate helpers keep the bit scrambling of each format in one place.
package decode_stage_pkg;

    localparam int unsigned DECODE_WIDTH_MAX = 4;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       is_alu_in_constant;
        logic       reg_wr_enable;
    } op_info_t;

    typedef struct packed {
        op_info_t    op;
        logic [31:0] imm;
        logic        illegal;
    } dec_op_info_t;

    typedef struct packed {
        logic [DECODE_WIDTH_MAX-1:0]             lane_valid;
        dec_op_info_t [DECODE_WIDTH_MAX-1:0]     op;
        logic [DECODE_WIDTH_MAX-1:0][31:0]       pc;
    } decode_bundle_t;

    function automatic logic [31:0] imm_i(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] insn);
        return {insn[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction RV32I decoder: field extraction,
// sign-extended immediate and illegal-encoding detection.
module decode_lane
    import decode_stage_pkg::*;
(
    input  logic         valid_i,
    input  logic [31:0]  insn_i,
    output dec_op_info_t opinfo_o
);

    logic [6:0]   opcode;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic         bad;
    dec_op_info_t d;

    assign opcode = insn_i[6:0];
    assign f3     = insn_i[14:12];
    assign f7     = insn_i[31:25];

    always_comb begin
        d           = '0;
        bad         = 1'b0;
        d.op.opcode = opcode;
        case (opcode)
            OPC_OP: begin
                d.op.rd            = insn_i[11:7];
                d.op.rs1           = insn_i[19:15];
                d.op.rs2           = insn_i[24:20];
                d.op.funct3        = f3;
                d.op.funct7        = f7;
                d.op.reg_wr_enable = 1'b1;
                bad = !((f7 == FUNCT7_BASE) ||
                        ((f7 == FUNCT7_ALT) && (f3 inside {3'b000, 3'b101})));
            end
            OPC_OP_IMM: begin
                d.op.rd                 = insn_i[11:7];
                d.op.rs1                = insn_i[19:15];
                d.op.funct3             = f3;
                d.op.is_alu_in_constant = 1'b1;
                d.op.reg_wr_enable      = 1'b1;
                d.imm                   = imm_i(insn_i);
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (f3 == 3'b001) begin
                    d.op.funct7 = f7;
                    bad         = (f7 != FUNCT7_BASE);
                end else if (f3 == 3'b101) begin
                    d.op.funct7 = f7;
                    bad         = !((f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT));
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                d.op.rd                 = insn_i[11:7];
                d.op.is_alu_in_constant = 1'b1;
                d.op.reg_wr_enable      = 1'b1;
                d.imm                   = imm_u(insn_i);
            end
            OPC_LOAD: begin
                d.op.rd                 = insn_i[11:7];
                d.op.rs1                = insn_i[19:15];
                d.op.funct3             = f3;
                d.op.is_load            = 1'b1;
                d.op.is_alu_in_constant = 1'b1;
                d.op.reg_wr_enable      = 1'b1;
                d.imm                   = imm_i(insn_i);
                bad                     = (f3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_STORE: begin
                d.op.rs1                = insn_i[19:15];
                d.op.rs2                = insn_i[24:20];
                d.op.funct3             = f3;
                d.op.is_store           = 1'b1;
                d.op.is_alu_in_constant = 1'b1;
                d.imm                   = imm_s(insn_i);
                bad                     = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                d.op.rs1       = insn_i[19:15];
                d.op.rs2       = insn_i[24:20];
                d.op.funct3    = f3;
                d.op.is_branch = 1'b1;
                d.imm          = imm_b(insn_i);
                bad            = (f3 inside {3'b010, 3'b011});
            end
            OPC_JAL: begin
                d.op.rd                 = insn_i[11:7];
                d.op.is_jump            = 1'b1;
                d.op.is_alu_in_constant = 1'b1;
                d.op.reg_wr_enable      = 1'b1;
                d.imm                   = imm_j(insn_i);
            end
            OPC_JALR: begin
                d.op.rd                 = insn_i[11:7];
                d.op.rs1                = insn_i[19:15];
                d.op.funct3             = f3;
                d.op.is_jump            = 1'b1;
                d.op.is_alu_in_constant = 1'b1;
                d.op.reg_wr_enable      = 1'b1;
                d.imm                   = imm_i(insn_i);
                bad                     = (f3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase

        if (insn_i[1:0] != 2'b11) begin
            bad = 1'b1;
        end

        // Illegal lanes must never cause architectural side effects.
        if (bad) begin
            d.op.reg_wr_enable = 1'b0;
            d.op.is_load       = 1'b0;
            d.op.is_store      = 1'b0;
            d.op.is_branch     = 1'b0;
            d.op.is_jump       = 1'b0;
            d.illegal          = 1'b1;
        end

        if (!valid_i) begin
            d = '0;
        end
    end

    assign opinfo_o = d;

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode stage: per-lane decoders, kill-after-illegal, and an
// output register backed by a one-entry skid buffer for a registered in_ready.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned DECODE_WIDTH       = 2,
    parameter int unsigned INSN_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter bit          KILL_AFTER_ILLEGAL = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DECODE_WIDTH-1:0]               in_lane_valid,
    input  logic [DECODE_WIDTH*INSN_WIDTH-1:0]    in_insn,
    input  logic [ADDR_WIDTH-1:0]                 in_pc,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DECODE_WIDTH-1:0]               out_lane_valid,
    output dec_op_info_t [DECODE_WIDTH-1:0]       out_opinfo,
    output logic [DECODE_WIDTH-1:0][ADDR_WIDTH-1:0] out_pc,
    output logic [DECODE_WIDTH-1:0]               out_illegal
);

    dec_op_info_t [DECODE_WIDTH-1:0]          dec_op;
    logic [DECODE_WIDTH-1:0]                  dec_lane_valid;
    logic [DECODE_WIDTH-1:0][ADDR_WIDTH-1:0]  dec_pc;
    logic                                     seen_illegal;

    logic                                     out_valid_d, out_valid_q;
    logic [DECODE_WIDTH-1:0]                  out_lane_valid_d, out_lane_valid_q;
    dec_op_info_t [DECODE_WIDTH-1:0]          out_op_d, out_op_q;
    logic [DECODE_WIDTH-1:0][ADDR_WIDTH-1:0]  out_pc_d, out_pc_q;

    logic                                     skid_valid_d, skid_valid_q;
    logic [DECODE_WIDTH-1:0]                  skid_lane_valid_d, skid_lane_valid_q;
    dec_op_info_t [DECODE_WIDTH-1:0]          skid_op_d, skid_op_q;
    logic [DECODE_WIDTH-1:0][ADDR_WIDTH-1:0]  skid_pc_d, skid_pc_q;

    logic                                     in_fire;
    logic                                     out_free;

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
        decode_lane u_lane (
            .valid_i  (in_lane_valid[g]),
            .insn_i   (in_insn[g*INSN_WIDTH +: 32]),
            .opinfo_o (dec_op[g])
        );
    end

    always_comb begin
        seen_illegal   = 1'b0;
        dec_lane_valid = in_lane_valid;
        for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
            dec_pc[i] = in_pc + ADDR_WIDTH'(4 * i);
            if (KILL_AFTER_ILLEGAL && seen_illegal) begin
                dec_lane_valid[i] = 1'b0;
            end
            if (in_lane_valid[i] && dec_op[i].illegal) begin
                seen_illegal = 1'b1;
            end
        end
    end

    // Flush blocks acceptance even though in_ready may read high that cycle.
    assign in_fire  = in_valid & ~skid_valid_q & ~flush;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d       = out_valid_q;
        out_lane_valid_d  = out_lane_valid_q;
        out_op_d          = out_op_q;
        out_pc_d          = out_pc_q;
        skid_valid_d      = skid_valid_q;
        skid_lane_valid_d = skid_lane_valid_q;
        skid_op_d         = skid_op_q;
        skid_pc_d         = skid_pc_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d      = 1'b1;
                out_lane_valid_d = skid_lane_valid_q;
                out_op_d         = skid_op_q;
                out_pc_d         = skid_pc_q;
                skid_valid_d     = 1'b0;
            end else if (in_fire) begin
                out_valid_d      = 1'b1;
                out_lane_valid_d = dec_lane_valid;
                out_op_d         = dec_op;
                out_pc_d         = dec_pc;
            end else begin
                out_valid_d      = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d      = 1'b1;
            skid_lane_valid_d = dec_lane_valid;
            skid_op_d         = dec_op;
            skid_pc_d         = dec_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q       <= 1'b0;
            out_lane_valid_q  <= '0;
            out_op_q          <= '0;
            out_pc_q          <= '0;
            skid_valid_q      <= 1'b0;
            skid_lane_valid_q <= '0;
            skid_op_q         <= '0;
            skid_pc_q         <= '0;
        end else begin
            out_valid_q       <= out_valid_d;
            out_lane_valid_q  <= out_lane_valid_d;
            out_op_q          <= out_op_d;
            out_pc_q          <= out_pc_d;
            skid_valid_q      <= skid_valid_d;
            skid_lane_valid_q <= skid_lane_valid_d;
            skid_op_q         <= skid_op_d;
            skid_pc_q         <= skid_pc_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
            out_illegal[i] = out_op_q[i].illegal;
        end
    end

    assign in_ready       = ~skid_valid_q;
    assign out_valid      = out_valid_q;
    assign out_lane_valid = out_lane_valid_q;
    assign out_opinfo     = out_op_q;
    assign out_pc         = out_pc_q;

endmodule
